// File: rtl/clkdiv_pkg.sv
// ---------------------------------------------------------------------------
// clkdiv_pkg
// Shared constants and helpers for the programmable dual-edge clock divider.
//   DIV_MIN : smallest divisor the divider accepts (anything lower is rejected)
//   half(n) : floor(n/2), the number of whole source cycles clk_p stays high
// ---------------------------------------------------------------------------
package clkdiv_pkg;

    localparam int DIV_MIN = 2;

    // Floor of n/2. For odd n the negedge stage adds the extra half cycle.
    function automatic logic [31:0] half(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clkdiv_neg_stage.sv
// ---------------------------------------------------------------------------
// clkdiv_neg_stage
// Re-registers the posedge-shaped divider waveform on the falling edge of the
// source clock. The divider ORs this copy in for odd divisors to stretch the
// high phase by half a cycle. Kept as its own instance so the negedge timing
// constraint applies to a single flop.
// Ports:
//   clk   in  source clock (captured on falling edge)
//   rst_n in  asynchronous active-low reset
//   d     in  posedge-domain waveform (clk_p)
//   q     out half-cycle delayed copy (clk_n)
// ---------------------------------------------------------------------------
module clkdiv_neg_stage (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_q;

    // Falling-edge capture of clk_p; reset forces it low with the rest of the divider.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/clkdiv_dual_edge_prog.sv
// ---------------------------------------------------------------------------
// clkdiv_dual_edge_prog
// Runtime-programmable integer clock divider with 50% duty for odd and even
// divisors. Divisor updates take effect only at period boundaries so clk_out
// never produces a runt pulse.
// Parameters:
//   CNT_W        width of divisor and counter
//   DIV_DEFAULT  divisor in force after reset (>= 2, < 2^CNT_W)
// Ports:
//   clk          in   source clock
//   rst_n        in   asynchronous active-low reset
//   en           in   run enable (a running period always completes)
//   div_load     in   strobe: capture div_val as the next divisor
//   div_val      in   requested divisor
//   clk_out      out  divided clock
//   period_tick  out  one-cycle pulse in the cnt==0 cycle while running
//   div_cur      out  divisor currently in force
//   div_err      out  one-cycle pulse after a load with div_val < 2
// ---------------------------------------------------------------------------
module clkdiv_dual_edge_prog
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_val,
    output logic             clk_out,
    output logic             period_tick,
    output logic [CNT_W-1:0] div_cur,
    output logic             div_err
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(DIV_MIN);
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DIV_DEFAULT);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_divCur;
    logic [CNT_W-1:0] r_pending;
    logic             r_pendingVld;
    logic             r_run;
    logic             r_clkP;
    logic             r_odd;
    logic             r_periodTick;
    logic             r_divErr;

    logic             w_clkN;
    logic [CNT_W-1:0] w_half;
    logic             w_loadOk;
    logic             w_lastCnt;
    logic             w_start;
    logic             w_boundary;
    logic [CNT_W-1:0] w_divNext;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_runNext;
    logic             w_clkPNext;

    assign w_half     = CNT_W'(half(32'(r_divCur)));
    assign w_loadOk   = div_load && (div_val >= MIN_DIV);
    assign w_lastCnt  = r_run && (r_cnt == (r_divCur - ONE));
    // Starting from idle is treated as a boundary so a divisor loaded while
    // stopped is picked up by the first period.
    assign w_start    = !r_run && en;
    assign w_boundary = w_lastCnt || w_start;

    // Next-state for counter, run flag, divisor and clk_p. At a boundary the
    // new period begins at cnt=0 with clk_p high (H >= 1 for any legal N),
    // unless en is low, in which case the divider parks with everything low.
    // A load landing on the boundary cycle takes priority over the pending value.
    always_comb begin
        w_divNext  = r_divCur;
        w_cntNext  = r_cnt;
        w_runNext  = r_run;
        w_clkPNext = r_clkP;
        if (w_boundary) begin
            if (w_loadOk) begin
                w_divNext = div_val;
            end else if (r_pendingVld) begin
                w_divNext = r_pending;
            end
            w_cntNext  = '0;
            w_runNext  = en;
            w_clkPNext = en;
        end else if (r_run) begin
            w_cntNext  = r_cnt + ONE;
            w_clkPNext = (r_cnt + ONE) < w_half;
        end
    end

    // Posedge state. The odd/even select only moves with the divisor at a
    // boundary, where clk_p and clk_n are both settled, so the output mux
    // cannot glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_divCur     <= DEF_DIV;
            r_pending    <= DEF_DIV;
            r_pendingVld <= 1'b0;
            r_run        <= 1'b0;
            r_clkP       <= 1'b0;
            r_odd        <= DEF_DIV[0];
            r_periodTick <= 1'b0;
            r_divErr     <= 1'b0;
        end else begin
            r_cnt    <= w_cntNext;
            r_run    <= w_runNext;
            r_clkP   <= w_clkPNext;
            r_divCur <= w_divNext;
            if (w_boundary) begin
                r_odd        <= w_divNext[0];
                r_pendingVld <= 1'b0;
            end else if (w_loadOk) begin
                r_pending    <= div_val;
                r_pendingVld <= 1'b1;
            end
            r_periodTick <= w_runNext && (w_cntNext == '0);
            r_divErr     <= div_load && (div_val < MIN_DIV);
        end
    end

    clkdiv_neg_stage u_negStage (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (r_clkP),
        .q     (w_clkN)
    );

    assign clk_out     = r_odd ? (r_clkP | w_clkN) : r_clkP;
    assign period_tick = r_periodTick;
    assign div_cur     = r_divCur;
    assign div_err     = r_divErr;

endmodule

// File: tb/tb_clkdiv_dual_edge_prog.sv
// ---------------------------------------------------------------------------
// tb_clkdiv_dual_edge_prog
// Directed bench for the programmable dual-edge divider. Waveform shape is
// measured in half-cycles of the source clock, sampled 1 time unit after
// every clock edge.
// ---------------------------------------------------------------------------
module tb_clkdiv_dual_edge_prog;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       div_load;
    logic [7:0] div_val;
    logic       clk_out;
    logic       period_tick;
    logic [7:0] div_cur;
    logic       div_err;

    int checks   = 0;
    int failures = 0;

    clkdiv_dual_edge_prog #(
        .CNT_W       (8),
        .DIV_DEFAULT (7)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .div_load    (div_load),
        .div_val     (div_val),
        .clk_out     (clk_out),
        .period_tick (period_tick),
        .div_cur     (div_cur),
        .div_err     (div_err)
    );

    // Free-running source clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic load, input logic [7:0] val);
        div_load = load;
        div_val  = val;
    endtask

    task automatic cycleStep();
        @(posedge clk);
        #1;
    endtask

    task automatic halfStep();
        @(posedge clk or negedge clk);
        #1;
    endtask

    // Cycles until period_tick is seen high, bounded.
    task automatic cyclesToTick(input string tag, input int expected);
        int n;
        n = 0;
        do begin
            cycleStep();
            n++;
        end while (period_tick !== 1'b1 && n < 600);
        checkOutput(tag, n, expected);
    endtask

    // Half-cycles clk_out stays high starting at the current sample.
    task automatic highHalvesFromNow(input string tag, input int expected);
        int n;
        n = 0;
        while (clk_out === 1'b1 && n < 600) begin
            n++;
            halfStep();
        end
        checkOutput(tag, n, expected);
    endtask

    // One full clk_out period from the next rising edge: high and total halves.
    task automatic measure(input string tag, input int expHigh, input int expPer);
        int n;
        int hi;
        int per;
        n   = 0;
        hi  = 0;
        per = 0;
        while (clk_out !== 1'b0 && n < 4000) begin halfStep(); n++; end
        while (clk_out !== 1'b1 && n < 4000) begin halfStep(); n++; end
        while (clk_out === 1'b1 && n < 4000) begin hi++;  halfStep(); n++; end
        per = hi;
        while (clk_out === 1'b0 && n < 4000) begin per++; halfStep(); n++; end
        checkOutput({tag, "_inbudget"}, (n < 4000) ? 32'd1 : 32'd0, 32'd1);
        checkOutput({tag, "_high"}, hi, expHigh);
        checkOutput({tag, "_period"}, per, expPer);
    endtask

    initial begin
        int hiCount;
        int tickCount;
        int n;

        rst_n = 1'b0;
        en    = 1'b0;
        applyStimulus(1'b0, 8'd0);

        // Reset state
        repeat (3) cycleStep();
        checkOutput("rst_clk_out", clk_out, 0);
        checkOutput("rst_tick", period_tick, 0);
        checkOutput("rst_div_cur", div_cur, 7);
        checkOutput("rst_div_err", div_err, 0);

        // 1: default divisor 7
        rst_n = 1'b1;
        en    = 1'b1;
        cycleStep();
        checkOutput("t1_start_clk_out", clk_out, 1);
        checkOutput("t1_start_tick", period_tick, 1);
        checkOutput("t1_div_cur", div_cur, 7);
        measure("t1", 7, 14);
        checkOutput("t1_tick_at_rise", period_tick, 1);
        cyclesToTick("t1_tick_spacing", 7);

        // 2: load 4 at cnt==2, current period completes first
        repeat (2) cycleStep();
        applyStimulus(1'b1, 8'd4);
        cycleStep();
        applyStimulus(1'b0, 8'd0);
        checkOutput("t2_div_cur_before", div_cur, 7);
        cyclesToTick("t2_finish_old", 4);
        checkOutput("t2_div_cur_after", div_cur, 4);
        highHalvesFromNow("t2_first_high", 4);
        cyclesToTick("t2_period", 2);

        // 3: load 5 in the last cycle, applied at that boundary
        repeat (3) cycleStep();
        applyStimulus(1'b1, 8'd5);
        cycleStep();
        applyStimulus(1'b0, 8'd0);
        checkOutput("t3_tick", period_tick, 1);
        checkOutput("t3_div_cur", div_cur, 5);
        highHalvesFromNow("t3_first_high", 5);
        cyclesToTick("t3_to_tick", 3);
        measure("t3", 5, 10);

        // 4: illegal loads rejected
        cycleStep();
        applyStimulus(1'b1, 8'd1);
        cycleStep();
        checkOutput("t4_err1", div_err, 1);
        applyStimulus(1'b1, 8'd0);
        cycleStep();
        checkOutput("t4_err0", div_err, 1);
        applyStimulus(1'b0, 8'd0);
        cycleStep();
        checkOutput("t4_err_clear", div_err, 0);
        checkOutput("t4_div_cur", div_cur, 5);
        measure("t4", 5, 10);
        checkOutput("t4_div_cur_after", div_cur, 5);

        // 5: N=9, en dropped at cnt==1
        applyStimulus(1'b1, 8'd9);
        cycleStep();
        applyStimulus(1'b0, 8'd0);
        cyclesToTick("t5_load9", 4);
        checkOutput("t5_div_cur", div_cur, 9);
        checkOutput("t5_high_cnt0", clk_out, 1);
        cycleStep();
        en = 1'b0;
        highHalvesFromNow("t5_rest_high", 7);
        hiCount   = 0;
        tickCount = 0;
        for (int i = 0; i < 60; i++) begin
            halfStep();
            if (clk_out === 1'b1) hiCount++;
            if (period_tick === 1'b1) tickCount++;
        end
        checkOutput("t5_idle_clk_out", hiCount, 0);
        checkOutput("t5_idle_tick", tickCount, 0);
        cycleStep();
        en = 1'b1;
        n  = 0;
        do begin
            halfStep();
            n++;
        end while (clk_out !== 1'b1 && n < 40);
        checkOutput("t5_restart_halves", n, 2);
        checkOutput("t5_restart_tick", period_tick, 1);
        measure("t5", 9, 18);

        // 6: async reset mid-high, pending discarded, then N=255
        applyStimulus(1'b1, 8'd3);
        cycleStep();
        applyStimulus(1'b0, 8'd0);
        halfStep();
        checkOutput("t6_high_before_rst", clk_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_clk_out", clk_out, 0);
        checkOutput("t6_rst_div_cur", div_cur, 7);
        checkOutput("t6_rst_tick", period_tick, 0);
        cycleStep();
        rst_n = 1'b1;
        cycleStep();
        checkOutput("t6_restart_div_cur", div_cur, 7);
        checkOutput("t6_restart_clk_out", clk_out, 1);
        measure("t6_default", 7, 14);
        applyStimulus(1'b1, 8'd255);
        cycleStep();
        applyStimulus(1'b0, 8'd0);
        cyclesToTick("t6_load255", 6);
        checkOutput("t6_div_cur_255", div_cur, 255);
        measure("t6_255", 255, 510);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
